// File: rtl/lcd_sched_pkg.sv
// rtl/lcd_sched_pkg.sv - shared state encoding and message codes for the LCD scheduler
package lcd_sched_pkg;

  localparam int MSG_W   = 3;
  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLD      = 2'd3
  } sched_state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  // Game message codes; 7 is reserved for the score screen
  localparam logic [MSG_W-1:0] MSG_WELCOME   = 3'd0;
  localparam logic [MSG_W-1:0] MSG_READY     = 3'd1;
  localparam logic [MSG_W-1:0] MSG_HIT       = 3'd2;
  localparam logic [MSG_W-1:0] MSG_MISS      = 3'd3;
  localparam logic [MSG_W-1:0] MSG_LEVEL_UP  = 3'd4;
  localparam logic [MSG_W-1:0] MSG_GAME_OVER = 3'd5;
  localparam logic [MSG_W-1:0] MSG_PAUSE     = 3'd6;
  localparam logic [MSG_W-1:0] MSG_SCORE     = 3'd7;

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// rtl/lcd_msg_scheduler_if.sv - request and LCD-controller signals of the scheduler
interface lcd_msg_scheduler_if;
  import lcd_sched_pkg::*;

  logic               a_valid;
  logic [MSG_W-1:0]   a_code;
  logic               a_ready;
  logic               b_valid;
  logic [SCORE_W-1:0] b_score;
  logic               b_ready;
  logic [MSG_W-1:0]   lcd_msg;
  logic [SCORE_W-1:0] lcd_score;
  logic               lcd_start;
  logic               lcd_done;
  logic               busy;
  logic               timeout_err;

  modport master (
    output a_valid, a_code, b_valid, b_score, lcd_done,
    input  a_ready, b_ready, lcd_msg, lcd_score, lcd_start, busy, timeout_err
  );

  modport slave (
    input  a_valid, a_code, b_valid, b_score, lcd_done,
    output a_ready, b_ready, lcd_msg, lcd_score, lcd_start, busy, timeout_err
  );

endinterface

// File: rtl/sched_timer.sv
// rtl/sched_timer.sv - loadable up-counter with clear and terminal compare
module sched_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_term,
  input  logic             clr,
  input  logic             en,
  output logic             hit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] term_q;

  // Load restarts the interval from zero; the counter saturates instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      term_q  <= '0;
    end else if (load) begin
      count_q <= '0;
      term_q  <= load_term;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = (count_q == term_q);

endmodule

// File: rtl/lcd_msg_scheduler.sv
// rtl/lcd_msg_scheduler.sv - arbitrates game-event and score requests onto the shared LCD controller
module lcd_msg_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 25
) (
  input  logic                clk,
  input  logic                reset,
  lcd_msg_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] TO_TERM   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  sched_state_t       state_q, state_d;
  logic               a_full_q;
  logic [MSG_W-1:0]   a_code_q;
  logic               b_pend_q;
  logic [SCORE_W-1:0] b_score_q;
  grant_t             last_grant_q;
  logic [MSG_W-1:0]   lcd_msg_q;
  logic [SCORE_W-1:0] lcd_score_q;
  logic               timeout_err_q;

  logic               grant_a, grant_b;
  logic               tmr_load, tmr_clr, tmr_en, tmr_hit;
  logic [CNT_W-1:0]   tmr_term;
  logic               set_timeout;

  sched_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_term (tmr_term),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .hit       (tmr_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    tmr_load    = 1'b0;
    tmr_term    = TO_TERM;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        // A yields only when it won last time and B is waiting
        if (a_full_q && !(last_grant_q == GRANT_A && b_pend_q)) begin
          grant_a = 1'b1;
          state_d = ST_ISSUE;
        end else if (b_pend_q) begin
          grant_b = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_load = 1'b1;
        tmr_term = TO_TERM;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmr_en = 1'b1;
        // Done takes priority over a timeout landing in the same cycle
        if (bus.lcd_done) begin
          if (HOLD_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_term = HOLD_TERM;
            state_d  = ST_HOLD;
          end
        end else if (tmr_hit) begin
          set_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        tmr_en = 1'b1;
        if (tmr_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_full_q      <= 1'b0;
      a_code_q      <= '0;
      b_pend_q      <= 1'b0;
      b_score_q     <= '0;
      last_grant_q  <= GRANT_B;
      lcd_msg_q     <= '0;
      lcd_score_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant_a) begin
        a_full_q <= 1'b0;
      end else if (bus.a_valid && !a_full_q) begin
        a_full_q <= 1'b1;
        a_code_q <= bus.a_code;
      end

      // A fresh score on the grant edge keeps B pending with the newer value
      if (bus.b_valid) begin
        b_pend_q  <= 1'b1;
        b_score_q <= bus.b_score;
      end else if (grant_b) begin
        b_pend_q <= 1'b0;
      end

      if (grant_a) begin
        lcd_msg_q    <= a_code_q;
        last_grant_q <= GRANT_A;
      end
      if (grant_b) begin
        lcd_msg_q    <= MSG_SCORE;
        lcd_score_q  <= b_score_q;
        last_grant_q <= GRANT_B;
      end

      if (set_timeout) timeout_err_q <= 1'b1;
    end
  end

  assign bus.a_ready     = ~a_full_q;
  assign bus.b_ready     = 1'b1;
  assign bus.lcd_msg     = lcd_msg_q;
  assign bus.lcd_score   = lcd_score_q;
  assign bus.lcd_start   = (state_q == ST_ISSUE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule
